// File: rtl/icache_axi_refill_if.sv
// AXI read-channel bundle (AR + R) between the icache refill engine and the bus.
interface icache_axi_refill_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/icache_axi_refill.sv
// Icache line refill over AXI read: one burst per cached miss, one beat per uncached fetch.
// Optional critical-word-first wrap bursts are enabled by defining ICACHE_CWF_EN.
module icache_axi_refill #(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic                       req_uc,
  input  logic                       dcache_active,
  icache_axi_refill_if.master        axi,
  output logic [32*LINE_WORDS-1:0]   line_data,
  output logic                       line_valid,
  output logic [31:0]                uc_rdata,
  output logic                       uc_valid,
  output logic                       rerr,
  output logic                       busy
`ifdef ICACHE_CWF_EN
  ,
  output logic                       crit_valid,
  output logic [31:0]                crit_word
`endif
);
  localparam int unsigned WB   = $clog2(LINE_WORDS);
  localparam logic [1:0]  INCR = 2'b01;
`ifdef ICACHE_CWF_EN
  localparam logic [1:0]  WRAP = 2'b10;
`endif

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t                      state;
  logic [LINE_WORDS-1:0][31:0] slots;
  logic [WB-1:0]               cnt, start, slot_idx;
  logic                        uc;
  logic                        beat;

  // Gating with aresetn keeps req_ready low while reset is held.
  assign req_ready   = aresetn & (state == IDLE) & req_valid & ~dcache_active;
  assign beat        = (state == R) & axi.rvalid & (axi.rid == AXI_ID);
  assign slot_idx    = start + cnt;  // WB-bit sum wraps modulo LINE_WORDS
  assign line_data   = slots;
  assign busy        = (state != IDLE);
  assign axi.arid    = AXI_ID;
  assign axi.arsize  = 3'b010;
  assign axi.rready  = 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      cnt         <= '0;
      start       <= '0;
      uc          <= 1'b0;
      slots       <= '0;
      uc_rdata    <= '0;
      rerr        <= 1'b0;
      line_valid  <= 1'b0;
      uc_valid    <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
      axi.arburst <= INCR;
`ifdef ICACHE_CWF_EN
      crit_valid  <= 1'b0;
      crit_word   <= '0;
`endif
    end else begin
      line_valid <= 1'b0;
      uc_valid   <= 1'b0;
`ifdef ICACHE_CWF_EN
      crit_valid <= 1'b0;
`endif
      case (state)
        IDLE: if (req_ready) begin
          state       <= AR;
          uc          <= req_uc;
          cnt         <= '0;
          rerr        <= 1'b0;
          axi.arvalid <= 1'b1;
          if (req_uc) begin
            axi.araddr  <= req_addr;
            axi.arlen   <= '0;
            axi.arburst <= INCR;
            start       <= '0;
          end else begin
            axi.arlen   <= 4'(LINE_WORDS - 1);
`ifdef ICACHE_CWF_EN
            axi.araddr  <= {req_addr[31:2], 2'b00};
            axi.arburst <= WRAP;
            start       <= req_addr[WB+1:2];
`else
            axi.araddr  <= req_addr & ~(32'(LINE_WORDS) * 32'd4 - 32'd1);
            axi.arburst <= INCR;
            start       <= '0;
`endif
          end
        end
        AR: if (axi.arready) begin
          axi.arvalid <= 1'b0;
          state       <= R;
        end
        R: if (beat) begin
          cnt <= cnt + 1'b1;
          if (axi.rresp != 2'b00) rerr <= 1'b1;
          if (uc) uc_rdata <= axi.rdata;
          else    slots[slot_idx] <= axi.rdata;
`ifdef ICACHE_CWF_EN
          if (!uc && cnt == '0) begin
            crit_valid <= 1'b1;
            crit_word  <= axi.rdata;
          end
`endif
          if (axi.rlast) begin
            state <= DONE;
            if (uc) uc_valid <= 1'b1;
            else begin
              line_valid <= 1'b1;
              // A short burst leaves stale slots behind; flag it.
              if (cnt != WB'(LINE_WORDS - 1)) rerr <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_axi_refill.sv
// Randomized bench for icache_axi_refill against an array-based line/AXI model.
module tb_icache_axi_refill;
  localparam int LW = 8;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic                 req_valid, req_ready, req_uc, dcache_active;
  logic [31:0]          req_addr;
  logic [32*LW-1:0]     line_data;
  logic                 line_valid, uc_valid, rerr, busy;
  logic [31:0]          uc_rdata;
`ifdef ICACHE_CWF_EN
  logic                 crit_valid;
  logic [31:0]          crit_word;
`endif

  icache_axi_refill_if axi();

  icache_axi_refill #(.LINE_WORDS(LW), .AXI_ID(4'h0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_uc(req_uc), .dcache_active(dcache_active), .axi(axi),
    .line_data(line_data), .line_valid(line_valid),
    .uc_rdata(uc_rdata), .uc_valid(uc_valid), .rerr(rerr), .busy(busy)
`ifdef ICACHE_CWF_EN
    , .crit_valid(crit_valid), .crit_word(crit_word)
`endif
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0, n_bad = 0;
  int lv_cnt = 0, uv_cnt = 0, cv_cnt = 0;
  int exp_lv = 0, exp_uv = 0, exp_cv = 0;
  logic [31:0] last_crit = '0;

  // model state
  logic [31:0] m_line [LW];
  logic [31:0] m_ucd, m_crit;
  int          m_start, m_cnt;
  bit          m_uc, m_err;

  always @(negedge aclk) begin
    if (line_valid) lv_cnt++;
    if (uc_valid)   uv_cnt++;
`ifdef ICACHE_CWF_EN
    if (crit_valid) begin cv_cnt++; last_crit = crit_word; end
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic chk_line(input string tag);
    for (int i = 0; i < LW; i++) chk(tag, line_data[32*i +: 32], m_line[i]);
  endtask

  task automatic start_req(input logic [31:0] addr, input bit uc, input int dc);
    logic [31:0] ea;
    req_addr = addr; req_uc = uc; req_valid = 1'b1; dcache_active = (dc > 0);
    #1;
    for (int i = 0; i < dc; i++) begin
      chk("blk_ready", req_ready, 0);
      chk("blk_arvalid", axi.arvalid, 0);
      tick();
    end
    dcache_active = 1'b0;
    #1;
    chk("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_uc = $urandom;
    m_uc = uc; m_cnt = 0; m_err = 0;
`ifdef ICACHE_CWF_EN
    m_start = uc ? 0 : int'((addr >> 2) % LW);
    ea = uc ? addr : (addr & ~32'd3);
`else
    m_start = 0;
    ea = uc ? addr : (addr / (LW * 4)) * (LW * 4);
`endif
    chk("busy", busy, 1);
    chk("rerr_clr", rerr, 0);
    chk("arvalid", axi.arvalid, 1);
    chk("araddr", axi.araddr, ea);
    chk("arlen", axi.arlen, uc ? 0 : LW - 1);
    chk("arsize", axi.arsize, 3'b010);
`ifdef ICACHE_CWF_EN
    chk("arburst", axi.arburst, uc ? 2'b01 : 2'b10);
`else
    chk("arburst", axi.arburst, 2'b01);
`endif
    chk("arid", axi.arid, 0);
    chk("rready", axi.rready, 1);
    // stray beats before R must not land anywhere
    for (int i = $urandom_range(0, 3); i > 0; i--) begin
      axi.rvalid = 1'b1; axi.rid = 4'h0; axi.rdata = $urandom; axi.rlast = 1'b1; axi.rresp = 2'b11;
      tick();
      chk("ar_hold", axi.arvalid, 1);
      chk("ar_addr_hold", axi.araddr, ea);
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("ar_done", axi.arvalid, 0);
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [1:0] resp, input bit last);
    if ($urandom_range(0, 3) == 0) begin
      axi.rvalid = 1'b1; axi.rid = 4'h1; axi.rdata = $urandom; axi.rlast = $urandom; axi.rresp = 2'b11;
      tick();
    end
    if ($urandom_range(0, 3) == 0) begin
      axi.rvalid = 1'b0; tick();
    end
    axi.rvalid = 1'b1; axi.rid = 4'h0; axi.rdata = data; axi.rresp = resp; axi.rlast = last;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    if (resp != 2'b00) m_err = 1;
    if (m_uc) m_ucd = data;
    else begin
      m_line[(m_start + m_cnt) % LW] = data;
`ifdef ICACHE_CWF_EN
      if (m_cnt == 0) begin m_crit = data; exp_cv++; end
`endif
    end
    m_cnt++;
    if (last && !m_uc && m_cnt != LW) m_err = 1;
  endtask

  task automatic finish_req();
    if (m_uc) exp_uv++; else exp_lv++;
    chk("line_valid", line_valid, !m_uc);
    chk("uc_valid", uc_valid, m_uc);
    chk("done_busy", busy, 1);
    chk("rerr", rerr, m_err);
    if (m_uc) chk("uc_rdata", uc_rdata, m_ucd);
    chk_line("line_word");
    req_valid = 1'b1; req_uc = 1'b0;
    #1;
    chk("bubble_ready", req_ready, 0);
    req_valid = 1'b0;
    tick();
    chk("pulse_end", line_valid | uc_valid, 0);
    chk("idle_busy", busy, 0);
    chk("rerr_sticky", rerr, m_err);
    chk_line("line_hold");
    chk("lv_count", lv_cnt, exp_lv);
    chk("uv_count", uv_cnt, exp_uv);
`ifdef ICACHE_CWF_EN
    chk("cv_count", cv_cnt, exp_cv);
    if (!m_uc) chk("crit_word", last_crit, m_crit);
`endif
  endtask

  task automatic xfer(input logic [31:0] addr, input bit uc, input int nb, input int errb,
                      input int dc, input bit seq, input logic [31:0] base);
    start_req(addr, uc, dc);
    for (int k = 0; k < nb; k++)
      send_beat(seq ? base + k : $urandom, (k == errb) ? 2'b10 : 2'b00, k == nb - 1);
    finish_req();
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_lv", line_valid, 0);
    chk("rst_uv", uc_valid, 0);
    chk("rst_rerr", rerr, 0);
    chk("rst_ucd", uc_rdata, 0);
    chk_line("rst_line");
  endtask

  initial begin
    aresetn = 1'b0; req_valid = 1'b1; req_addr = '0; req_uc = 1'b0; dcache_active = 1'b0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    for (int i = 0; i < LW; i++) m_line[i] = '0;
    m_ucd = '0; m_crit = '0;
    tick(); tick();
    chk_reset_vals();
    req_valid = 1'b0;
    aresetn = 1'b1;
    tick();

    xfer(32'h1000_0014, 1'b0, LW, -1, 0, 1'b1, 32'hA0);      // line fill, A0..A7
    xfer(32'hBFC0_0008, 1'b1, 1, -1, 0, 1'b1, 32'h1234_5678); // uncached single beat
    xfer(32'h2000_0040, 1'b0, LW, -1, 3, 1'b0, 0);           // held off by dcache
    xfer(32'h3000_0008, 1'b0, LW, 2, 0, 1'b0, 0);            // error response on beat 2
    xfer(32'h4000_001C, 1'b0, 5, -1, 0, 1'b0, 0);            // short burst
    xfer(32'h4000_0100, 1'b0, LW, -1, 0, 1'b0, 0);           // clears rerr

    // reset in the middle of a burst
    start_req(32'h5000_0024, 1'b0, 0);
    for (int k = 0; k < 3; k++) send_beat($urandom, 2'b00, 1'b0);
    req_valid = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    for (int i = 0; i < LW; i++) m_line[i] = '0;
    m_ucd = '0;
    chk_reset_vals();
    req_valid = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    tick();
    chk("abort_lv", lv_cnt, exp_lv);
    xfer(32'h5000_0024, 1'b0, LW, -1, 0, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      bit uc = ($urandom_range(0, 3) == 0);
      int nb = uc ? 1 : (($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LW)) : LW);
      int eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      xfer($urandom, uc, nb, eb, $urandom_range(0, 2), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
